fir_capture_buffer: RTL and testbench

Triggered capture buffer that sits directly downstream of the adaptive FIR and consumes its filtered output stream. It keeps a circular pre-trigger history, fires on an external trigger or on the absolute filter output crossing a programmable threshold, and then fills the remaining post-trigger window. It then replays the whole window oldest-first over a valid/ready stream, so an off-chip link or a logic-analyzer probe can read filter behaviour around the event.

---
 rtl/fir_capture_pkg.sv | 25 ++
 rtl/capture_ram.sv | 35 +++
 rtl/fir_capture_buffer.sv | 216 +++++++++++++++++++++
 tb/tb_fir_capture_buffer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_capture_pkg.sv
// Shared definitions for the triggered FIR capture buffer: state encodings
// and the capture-depth helper.
package fir_capture_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_POST    = 2'd2;
    localparam logic [1:0] S_READOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_ARMED   = S_ARMED,
        ST_POST    = S_POST,
        ST_READOUT = S_READOUT
    } cap_state_t;

    localparam int NB_DEPTH_DEF = 10;
    localparam int DEPTH_DEF    = 2 ** NB_DEPTH_DEF;

    // Capture depth in samples for a given log2 depth.
    function automatic int depth_of(input int nb_depth);
        return 2 ** nb_depth;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one read port with a
// registered output that holds its value while the read enable is low.
// The array has no reset so it maps onto block RAM.
module capture_ram
    import fir_capture_pkg::*;
#(
    parameter int NB_DATA = 21,
    parameter int NB_ADDR = 10
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [NB_ADDR-1:0] wr_addr,
    input  logic [NB_DATA-1:0] wr_data,
    input  logic               rd_en,
    input  logic [NB_ADDR-1:0] rd_addr,
    output logic [NB_DATA-1:0] rd_data
);

    logic [NB_DATA-1:0] mem_r [2**NB_ADDR];

    // Write port: store one sample per enabled cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port: registered read; output holds when not enabled (acts as a pipeline stage).
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/fir_capture_buffer.sv
// Triggered capture buffer behind the adaptive FIR: circular pre-trigger
// history, external or level trigger, post-trigger fill, then an oldest-first
// replay of the whole window over a valid/ready stream.
module fir_capture_buffer
    import fir_capture_pkg::*;
#(
    parameter int NB_DATA  = 21,
    parameter int NB_DEPTH = 10,
    parameter int PRE      = 256
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    input  logic               i_arm,
    input  logic               i_abort,
    input  logic               i_trig,
    input  logic [NB_DATA-2:0] i_threshold,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_last,
    output logic               o_done,
    output logic               o_busy,
    output logic [1:0]         o_state
);

    localparam int DEPTH = depth_of(NB_DEPTH);
    localparam logic [NB_DEPTH-1:0] PRE_C    = NB_DEPTH'(PRE);
    localparam logic [NB_DEPTH:0]   POST_LEN = (NB_DEPTH+1)'(DEPTH - PRE);
    localparam logic [NB_DEPTH:0]   DEPTH_C  = (NB_DEPTH+1)'(DEPTH);
    localparam logic [NB_DEPTH:0]   LAST_IDX = (NB_DEPTH+1)'(DEPTH - 1);

    // Magnitude of a signed sample in NB_DATA-1 bits; the most negative value
    // has no positive twin and saturates to all-ones.
    function automatic logic [NB_DATA-2:0] abs_mag(input logic [NB_DATA-1:0] x);
        logic [NB_DATA-1:0] neg;
        neg = ~x + {{(NB_DATA-1){1'b0}}, 1'b1};
        if (!x[NB_DATA-1]) begin
            abs_mag = x[NB_DATA-2:0];
        end else if (neg[NB_DATA-1]) begin
            abs_mag = {(NB_DATA-1){1'b1}};
        end else begin
            abs_mag = neg[NB_DATA-2:0];
        end
    endfunction

    cap_state_t          state_r;
    logic                busy_r;
    logic [NB_DEPTH-1:0] wp_r;
    logic [NB_DEPTH-1:0] rp_r;
    logic [NB_DEPTH-1:0] pc_r;
    logic [NB_DEPTH:0]   post_r;
    logic [NB_DEPTH:0]   rd_cnt_r;
    logic                s1_vld_r;
    logic                s1_last_r;
    logic [NB_DATA-1:0]  o_data_r;
    logic                o_valid_r;
    logic                o_last_r;
    logic                o_done_r;

    logic [NB_DATA-2:0]  mag_s;
    logic                level_hit_s;
    logic                trig_s;
    logic                wr_en_s;
    logic                out_ready_s;
    logic                xfer_last_s;
    logic                rd_issue_s;
    logic [NB_DEPTH-1:0] wp_inc_s;
    logic [NB_DATA-1:0]  ram_rdata_s;

    // Per-cycle decode: qualified trigger, write enable and readout handshake.
    always_comb begin
        mag_s       = abs_mag(i_data);
        level_hit_s = (i_threshold != {(NB_DATA-1){1'b0}}) && (mag_s >= i_threshold);
        trig_s      = (state_r == ST_ARMED) && i_valid && (pc_r == PRE_C)
                      && (i_trig || level_hit_s);
        wr_en_s     = ((state_r == ST_ARMED) || (state_r == ST_POST)) && i_valid && !i_abort;
        out_ready_s = !o_valid_r || i_ready;
        xfer_last_s = o_valid_r && i_ready && o_last_r;
        rd_issue_s  = (state_r == ST_READOUT) && (rd_cnt_r != DEPTH_C)
                      && (!s1_vld_r || out_ready_s) && !i_abort;
        wp_inc_s    = wp_r + NB_DEPTH'(1);
    end

    capture_ram #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_DEPTH)
    ) u_ram (
        .clk     (i_clk),
        .wr_en   (wr_en_s),
        .wr_addr (wp_r),
        .wr_data (i_data),
        .rd_en   (rd_issue_s),
        .rd_addr (rp_r),
        .rd_data (ram_rdata_s)
    );

    // Capture FSM with write/read pointers, pre-count and post-count.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            wp_r     <= '0;
            rp_r     <= '0;
            pc_r     <= '0;
            post_r   <= '0;
            rd_cnt_r <= '0;
        end else if (i_abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_arm) begin
                        state_r  <= ST_ARMED;
                        busy_r   <= 1'b1;
                        wp_r     <= '0;
                        pc_r     <= '0;
                        rd_cnt_r <= '0;
                    end
                end
                ST_ARMED: begin
                    if (i_valid) begin
                        wp_r <= wp_inc_s;
                        if (pc_r != PRE_C) begin
                            pc_r <= pc_r + NB_DEPTH'(1);
                        end
                        if (trig_s) begin
                            post_r <= (NB_DEPTH+1)'(1);
                            if (POST_LEN == (NB_DEPTH+1)'(1)) begin
                                // Trigger sample alone completes the window.
                                state_r  <= ST_READOUT;
                                rp_r     <= wp_inc_s;
                                rd_cnt_r <= '0;
                            end else begin
                                state_r <= ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (i_valid) begin
                        wp_r   <= wp_inc_s;
                        post_r <= post_r + (NB_DEPTH+1)'(1);
                        if ((post_r + (NB_DEPTH+1)'(1)) == POST_LEN) begin
                            // Slot after the final write holds the oldest sample.
                            state_r  <= ST_READOUT;
                            rp_r     <= wp_inc_s;
                            rd_cnt_r <= '0;
                        end
                    end
                end
                ST_READOUT: begin
                    if (rd_issue_s) begin
                        rp_r     <= rp_r + NB_DEPTH'(1);
                        rd_cnt_r <= rd_cnt_r + (NB_DEPTH+1)'(1);
                    end
                    if (xfer_last_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Readout pipeline: RAM output stage feeding the output/skid register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_vld_r  <= 1'b0;
            s1_last_r <= 1'b0;
            o_data_r  <= '0;
            o_valid_r <= 1'b0;
            o_last_r  <= 1'b0;
            o_done_r  <= 1'b0;
        end else if (i_abort) begin
            s1_vld_r  <= 1'b0;
            s1_last_r <= 1'b0;
            o_valid_r <= 1'b0;
            o_last_r  <= 1'b0;
            o_done_r  <= 1'b0;
        end else begin
            o_done_r <= xfer_last_s;
            if (rd_issue_s) begin
                s1_vld_r  <= 1'b1;
                s1_last_r <= (rd_cnt_r == LAST_IDX);
            end else if (s1_vld_r && out_ready_s) begin
                s1_vld_r  <= 1'b0;
                s1_last_r <= 1'b0;
            end
            if (out_ready_s) begin
                if (s1_vld_r) begin
                    o_data_r  <= ram_rdata_s;
                    o_valid_r <= 1'b1;
                    o_last_r  <= s1_last_r;
                end else begin
                    o_valid_r <= 1'b0;
                    o_last_r  <= 1'b0;
                end
            end
        end
    end

    assign o_data  = o_data_r;
    assign o_valid = o_valid_r;
    assign o_last  = o_last_r;
    assign o_done  = o_done_r;
    assign o_busy  = busy_r;
    assign o_state = state_r;

endmodule

// File: tb/tb_fir_capture_buffer.sv
// Self-checking bench for fir_capture_buffer (DEPTH=16, PRE=4): directed
// ramp scenarios plus a randomized phase, all checked against a queue-based
// reference model of the capture window.
module tb_fir_capture_buffer;

    localparam int NB_DATA  = 21;
    localparam int NB_DEPTH = 4;
    localparam int PRE      = 4;
    localparam int DEPTH    = 16;
    localparam int POST_N   = DEPTH - PRE;
    localparam int MAX_MAG  = (2 ** (NB_DATA - 1)) - 1;

    logic               i_clk;
    logic               i_rst;
    logic [NB_DATA-1:0] i_data;
    logic               i_valid;
    logic               i_arm;
    logic               i_abort;
    logic               i_trig;
    logic [NB_DATA-2:0] i_threshold;
    logic [NB_DATA-1:0] o_data;
    logic               o_valid;
    logic               i_ready;
    logic               o_last;
    logic               o_done;
    logic               o_busy;
    logic [1:0]         o_state;

    fir_capture_buffer #(
        .NB_DATA  (NB_DATA),
        .NB_DEPTH (NB_DEPTH),
        .PRE      (PRE)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_arm       (i_arm),
        .i_abort     (i_abort),
        .i_trig      (i_trig),
        .i_threshold (i_threshold),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_last      (o_last),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_state     (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: 0 idle, 1 armed, 2 post, 3 readout
    int  m_st        = 0;
    int  hist[$];
    int  exp_q[$];
    int  obs_q[$];
    int  n_since_arm = 0;
    int  post_cnt    = 0;
    int  ro_idx      = 0;
    int  ro_cyc      = 0;
    bit  seen_valid  = 1'b0;
    bit  exp_done    = 1'b0;
    int  thr_int     = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mag(input int v);
        int a;
        a = (v < 0) ? -v : v;
        if (a > MAX_MAG) a = MAX_MAG;
        return a;
    endfunction

    task automatic enter_readout();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(hist[hist.size() - DEPTH + i]);
        obs_q.delete();
        m_st       = 3;
        ro_idx     = 0;
        ro_cyc     = 0;
        seen_valid = 1'b0;
    endtask

    // One clock: check outputs (at negedge), drive inputs, step the model.
    task automatic cycle(input bit v, input int d, input bit tr, input bit arm,
                         input bit ab, input bit rdy);
        bit xfer;
        bit q;
        int od;
        chk("o_state", o_state, m_st);
        chk("o_busy", o_busy, (m_st != 0));
        chk("o_done", o_done, exp_done);
        if (m_st != 3) begin
            chk("o_valid_outside_readout", o_valid, 1'b0);
        end else if (o_valid === 1'b1) begin
            if (!seen_valid) begin
                chk("first_valid_latency", ro_cyc, 2);
                seen_valid = 1'b1;
            end
            if (ro_idx < DEPTH) begin
                chk("o_data", $signed(o_data), exp_q[ro_idx]);
                chk("o_last", o_last, (ro_idx == DEPTH - 1));
            end else begin
                chk("extra_valid", ro_idx, DEPTH - 1);
            end
        end
        xfer = (o_valid === 1'b1) && rdy;
        od   = $signed(o_data);
        i_valid = v;
        i_data  = NB_DATA'(d);
        i_trig  = tr;
        i_arm   = arm;
        i_abort = ab;
        i_ready = rdy;
        @(posedge i_clk);
        exp_done = 1'b0;
        if (ab) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (arm) begin
                    m_st = 1;
                    hist.delete();
                    n_since_arm = 0;
                end
                1: if (v) begin
                    q = (n_since_arm >= PRE) && (tr || (thr_int != 0 && mag(d) >= thr_int));
                    hist.push_back(d);
                    n_since_arm++;
                    if (q) begin
                        post_cnt = 1;
                        if (post_cnt == POST_N) enter_readout();
                        else m_st = 2;
                    end
                end
                2: if (v) begin
                    hist.push_back(d);
                    post_cnt++;
                    if (post_cnt == POST_N) enter_readout();
                end
                3: begin
                    ro_cyc++;
                    if (xfer) begin
                        obs_q.push_back(od);
                        if (ro_idx == DEPTH - 1) begin
                            m_st     = 0;
                            exp_done = 1'b1;
                        end
                        ro_idx++;
                    end
                end
                default: m_st = 0;
            endcase
        end
        @(negedge i_clk);
    endtask

    // Arm, feed a ramp (with optional substituted sample), run until idle.
    task automatic run_ramp(input int trig_a, input int trig_b, input int sub_at,
                            input int sub_val, input bit bp, input int abort_after);
        int  k;
        int  guard;
        int  d;
        bit  rdy;
        bit  ab;
        k     = 0;
        guard = 0;
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        while (m_st != 0 && guard < 300) begin
            case (guard % 4)
                0, 3:    rdy = 1'b1;
                default: rdy = !bp;
            endcase
            ab = (abort_after > 0) && (m_st == 3) && (obs_q.size() == abort_after);
            d  = (k == sub_at) ? sub_val : k;
            cycle(1'b1, d, (k == trig_a) || (k == trig_b), 1'b0, ab, rdy);
            k++;
            guard++;
        end
        chk("capture_timeout", (guard < 300), 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [NB_DATA-1:0] rr;
        int guard;
        i_rst = 1'b0; i_data = '0; i_valid = 1'b0; i_arm = 1'b0; i_abort = 1'b0;
        i_trig = 1'b0; i_threshold = '0; i_ready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("reset_o_valid", o_valid, 1'b0);
        chk("reset_o_last", o_last, 1'b0);
        chk("reset_o_data", o_data, 0);
        chk("reset_o_state", o_state, 0);
        i_rst = 1'b1;
        @(negedge i_clk);

        // External trigger at sample 10 -> window 6..21
        thr_int = 0; i_threshold = '0;
        run_ramp(10, -1, -1, 0, 1'b0, 0);
        chk("ext_count", obs_q.size(), 16);
        if (obs_q.size() == 16) begin
            chk("ext_first", obs_q[0], 6);
            chk("ext_trig_idx", obs_q[PRE], 10);
            chk("ext_last", obs_q[15], 21);
        end

        // Early trigger ignored, second at 7 -> window 3..18
        run_ramp(2, 7, -1, 0, 1'b0, 0);
        chk("early_count", obs_q.size(), 16);
        if (obs_q.size() == 16) begin
            chk("early_first", obs_q[0], 3);
            chk("early_last", obs_q[15], 18);
        end

        // Level trigger on -100 at sample 9
        thr_int = 100; i_threshold = 20'd100;
        run_ramp(-1, -1, 9, -100, 1'b0, 0);
        chk("level_count", obs_q.size(), 16);
        if (obs_q.size() == 16) chk("level_idx4", obs_q[4], -100);

        // Most negative sample against maximum threshold
        thr_int = MAX_MAG; i_threshold = 20'hFFFFF;
        run_ramp(-1, -1, 6, -(2 ** 20), 1'b0, 0);
        chk("minval_count", obs_q.size(), 16);
        if (obs_q.size() == 16) chk("minval_idx4", obs_q[4], -(2 ** 20));

        // Back-pressure 1,0,0,1
        thr_int = 0; i_threshold = '0;
        run_ramp(10, -1, -1, 0, 1'b1, 0);
        chk("bp_count", obs_q.size(), 16);
        for (int i = 0; i < 16 && i < obs_q.size(); i++) chk("bp_order", obs_q[i], 6 + i);

        // Abort after 5th transfer, then fresh capture
        run_ramp(10, -1, -1, 0, 1'b0, 5);
        chk("abort_count", obs_q.size(), 5);
        run_ramp(5, -1, -1, 0, 1'b0, 0);
        chk("rearm_count", obs_q.size(), 16);
        if (obs_q.size() == 16) chk("rearm_first", obs_q[0], 1);

        // Async reset mid-POST
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) cycle(1'b1, k, (k == 5), 1'b0, 1'b0, 1'b1);
        chk("pre_reset_in_post", m_st, 2);
        #2 i_rst = 1'b0;
        #1;
        chk("areset_o_valid", o_valid, 1'b0);
        chk("areset_o_last", o_last, 1'b0);
        chk("areset_o_done", o_done, 1'b0);
        chk("areset_o_busy", o_busy, 1'b0);
        chk("areset_o_data", o_data, 0);
        chk("areset_o_state", o_state, 0);
        m_st = 0; exp_done = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        for (int k = 0; k < 5; k++) cycle(1'b1, k, 1'b1, 1'b0, 1'b0, 1'b1);
        run_ramp(6, -1, -1, 0, 1'b0, 0);
        chk("post_reset_count", obs_q.size(), 16);

        // Randomized phase
        for (int n = 0; n < 2500; n++) begin
            if (n % 500 == 0) begin
                thr_int = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, MAX_MAG));
                i_threshold = (NB_DATA-1)'(thr_int);
            end
            rr = NB_DATA'($urandom);
            cycle($urandom_range(0, 3) != 0, int'($signed(rr)), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0,
                  $urandom_range(0, 9) < 7);
        end
        guard = 0;
        while (m_st != 0 && guard < 400) begin
            cycle(1'b1, guard, 1'b1, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("drain_timeout", (guard < 400), 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
